// File: rtl/exec_core_units.sv
// exec_core_units: execute/writeback building blocks of the RV32 pipeline.
//   exec_alu     - combinational ALU
//   exec_regfile - 32 x XLEN integer register file, 2 async read ports, 1 write port
//   exec_csr     - machine-mode CSR file with a free-running 64-bit cycle counter
//
// Ports (top):
//   clk, reset                      clock, synchronous active-high reset
//   alu_op1/op2/fun -> alu_out      ALU operands, function, combinational result
//   rf_rs1_addr/rf_rs2_addr -> rf_rs1_data/rf_rs2_data   async reads, x0 reads 0
//   rf_waddr/rf_wdata/rf_we         write port, committed on the rising edge
//   csr_cmd/csr_addr/csr_wdata      CSR command (N/W/S/C), address, operand
//   csr_rdata                       pre-update value of the addressed CSR

module exec_alu #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [3:0]      fun,
    output logic [XLEN-1:0] result
);
    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;
    logic           lt_s;
    logic           lt_u;

    // Only the low shift-amount bits of op2 matter for shifts.
    assign shamt = op2[SHW-1:0];
    assign lt_s  = $signed(op1) < $signed(op2);
    assign lt_u  = op1 < op2;

    always_comb begin
        result = '0;
        case (fun)
            4'd0:    result = op1 + op2;
            4'd1:    result = op1 - op2;
            4'd2:    result = op1 << shamt;
            4'd3:    result = op1 >> shamt;
            4'd4:    result = $unsigned($signed(op1) >>> shamt);
            4'd5:    result = op1 & op2;
            4'd6:    result = op1 | op2;
            4'd7:    result = op1 ^ op2;
            4'd8:    result = {{(XLEN-1){1'b0}}, lt_s};
            4'd9:    result = {{(XLEN-1){1'b0}}, lt_u};
            4'd10:   result = op1;
            default: result = '0;
        endcase
    end
endmodule

module exec_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic            we
);
    logic [XLEN-1:0] regs [NREGS];

    // Reset wins over a same-cycle write; x0 is never written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we && waddr != 5'd0) begin
            regs[waddr] <= wdata;
        end
    end

    // No bypass: a same-cycle write is visible only after the edge.
    assign rs1_data = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];
endmodule

module exec_csr #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      cmd,
    input  logic [11:0]     addr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata
);
    localparam logic [1:0]  CMD_N = 2'd0;
    localparam logic [1:0]  CMD_W = 2'd1;
    localparam logic [1:0]  CMD_S = 2'd2;
    localparam logic [1:0]  CMD_C = 2'd3;

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_CYCLE    = 12'hC00;
    localparam logic [11:0] A_CYCLEH   = 12'hC80;

    logic [XLEN-1:0] mstatus, mtvec, mscratch, mepc, mcause;
    logic [63:0]     cycle_q;
    logic [XLEN-1:0] wval;

    always_comb begin
        rdata = '0;
        case (addr)
            A_MSTATUS:  rdata = mstatus;
            A_MTVEC:    rdata = mtvec;
            A_MSCRATCH: rdata = mscratch;
            A_MEPC:     rdata = mepc;
            A_MCAUSE:   rdata = mcause;
            A_CYCLE:    rdata = cycle_q[31:0];
            A_CYCLEH:   rdata = cycle_q[63:32];
            default:    rdata = '0;
        endcase
    end

    // Read-modify-write value built from the pre-update read.
    always_comb begin
        wval = rdata;
        case (cmd)
            CMD_W:   wval = wdata;
            CMD_S:   wval = rdata | wdata;
            CMD_C:   wval = rdata & ~wdata;
            default: wval = rdata;
        endcase
    end

    // cycle/cycleh and unimplemented addresses fall through to default and
    // are therefore read-only / ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            mstatus  <= '0;
            mtvec    <= '0;
            mscratch <= '0;
            mepc     <= '0;
            mcause   <= '0;
            cycle_q  <= '0;
        end else begin
            cycle_q <= cycle_q + 64'd1;
            if (cmd != CMD_N) begin
                case (addr)
                    A_MSTATUS:  mstatus  <= wval;
                    A_MTVEC:    mtvec    <= wval;
                    A_MSCRATCH: mscratch <= wval;
                    A_MEPC:     mepc     <= {wval[XLEN-1:2], 2'b00};
                    A_MCAUSE:   mcause   <= wval;
                    default:    ;
                endcase
            end
        end
    end
endmodule

module exec_core_units #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] alu_op1,
    input  logic [XLEN-1:0] alu_op2,
    input  logic [3:0]      alu_fun,
    output logic [XLEN-1:0] alu_out,
    input  logic [4:0]      rf_rs1_addr,
    input  logic [4:0]      rf_rs2_addr,
    output logic [XLEN-1:0] rf_rs1_data,
    output logic [XLEN-1:0] rf_rs2_data,
    input  logic [4:0]      rf_waddr,
    input  logic [XLEN-1:0] rf_wdata,
    input  logic            rf_we,
    input  logic [1:0]      csr_cmd,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata
);
    exec_alu #(.XLEN(XLEN)) u_alu (
        .op1    (alu_op1),
        .op2    (alu_op2),
        .fun    (alu_fun),
        .result (alu_out)
    );

    exec_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
        .clk      (clk),
        .reset    (reset),
        .rs1_addr (rf_rs1_addr),
        .rs2_addr (rf_rs2_addr),
        .rs1_data (rf_rs1_data),
        .rs2_data (rf_rs2_data),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata),
        .we       (rf_we)
    );

    exec_csr #(.XLEN(XLEN)) u_csr (
        .clk   (clk),
        .reset (reset),
        .cmd   (csr_cmd),
        .addr  (csr_addr),
        .wdata (csr_wdata),
        .rdata (csr_rdata)
    );
endmodule

// File: tb/tb_exec_core_units.sv
// Scoreboard bench for exec_core_units: stimulus sets inputs just after a
// rising edge and queues expected values; the monitor checks them on the
// following falling edge.
module tb_exec_core_units;
    logic        clk;
    logic        reset;
    logic [31:0] alu_op1, alu_op2, alu_out;
    logic [3:0]  alu_fun;
    logic [4:0]  rf_rs1_addr, rf_rs2_addr, rf_waddr;
    logic [31:0] rf_rs1_data, rf_rs2_data, rf_wdata;
    logic        rf_we;
    logic [1:0]  csr_cmd;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, csr_rdata;

    exec_core_units dut (
        .clk(clk), .reset(reset),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_fun(alu_fun), .alu_out(alu_out),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_we(rf_we),
        .csr_cmd(csr_cmd), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int S_ALU = 0, S_RS1 = 1, S_RS2 = 2, S_CSR = 3;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Monitor: consume every expectation queued for this cycle.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [31:0] got;
            e = q.pop_front();
            case (e.sel)
                S_ALU:   got = alu_out;
                S_RS1:   got = rf_rs1_data;
                S_RS2:   got = rf_rs2_data;
                default: got = csr_rdata;
            endcase
            n_vec++;
            if (got !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %08h expected %08h", e.name, got, e.exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input string name, input int sel, input logic [31:0] exp);
        exp_t e;
        e.name = name; e.sel = sel; e.exp = exp;
        q.push_back(e);
    endtask

    task automatic alu_vec(input string name, input logic [3:0] fun,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        step();
        alu_fun = fun; alu_op1 = a; alu_op2 = b;
        expect_v(name, S_ALU, exp);
    endtask

    task automatic csr_op(input string name, input logic [1:0] cmd, input logic [11:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_prior);
        step();
        csr_cmd = cmd; csr_addr = a; csr_wdata = wd;
        expect_v(name, S_CSR, exp_prior);
    endtask

    initial begin
        reset = 1'b1;
        alu_op1 = '0; alu_op2 = '0; alu_fun = '0;
        rf_rs1_addr = 5'd5; rf_rs2_addr = 5'd9; rf_waddr = '0; rf_wdata = '0; rf_we = 1'b0;
        csr_cmd = 2'd0; csr_addr = 12'h300; csr_wdata = '0;

        // Reset state
        step();
        step();
        expect_v("rst_x5", S_RS1, 32'h0);
        expect_v("rst_x9", S_RS2, 32'h0);
        expect_v("rst_mstatus", S_CSR, 32'h0);
        step();
        csr_addr = 12'hC00;
        expect_v("rst_cycle", S_CSR, 32'h0);
        step();
        reset = 1'b0;

        // ALU sweep
        alu_vec("alu_add",  4'd0,  32'hFFFF_FFF0, 32'h14, 32'h0000_0004);
        alu_vec("alu_sub",  4'd1,  32'hFFFF_FFF0, 32'h14, 32'hFFFF_FFDC);
        alu_vec("alu_sll",  4'd2,  32'hFFFF_FFF0, 32'h14, 32'hFF00_0000);
        alu_vec("alu_and",  4'd5,  32'hFFFF_FFF0, 32'h14, 32'h0000_0010);
        alu_vec("alu_or",   4'd6,  32'hFFFF_FFF0, 32'h14, 32'hFFFF_FFF4);
        alu_vec("alu_xor",  4'd7,  32'hFFFF_FFF0, 32'h14, 32'hFFFF_FFE4);
        alu_vec("alu_sra",  4'd4,  32'hFFFF_FFF0, 32'h24, 32'hFFFF_FFFF);
        alu_vec("alu_srl",  4'd3,  32'hFFFF_FFF0, 32'h24, 32'h0FFF_FFFF);
        alu_vec("alu_slt",  4'd8,  32'hFFFF_FFF0, 32'h24, 32'h1);
        alu_vec("alu_sltu", 4'd9,  32'hFFFF_FFF0, 32'h24, 32'h0);
        alu_vec("alu_cpy",  4'd10, 32'hFFFF_FFF0, 32'h24, 32'hFFFF_FFF0);
        alu_vec("alu_f12",  4'd12, 32'hFFFF_FFF0, 32'h24, 32'h0);
        alu_vec("alu_f15",  4'd15, 32'h1234_5678, 32'h1,  32'h0);

        // RF basic: no bypass, both ports same register
        step();
        rf_we = 1'b1; rf_waddr = 5'd5; rf_wdata = 32'hDEAD_BEEF;
        rf_rs1_addr = 5'd5; rf_rs2_addr = 5'd5;
        expect_v("rf_nobypass", S_RS1, 32'h0);
        step();
        rf_we = 1'b0;
        expect_v("rf_x5_p1", S_RS1, 32'hDEAD_BEEF);
        expect_v("rf_x5_p2", S_RS2, 32'hDEAD_BEEF);
        step();
        rf_we = 1'b1; rf_waddr = 5'd0; rf_wdata = 32'h1234; rf_rs1_addr = 5'd0;
        expect_v("rf_x0_same", S_RS1, 32'h0);
        step();
        rf_we = 1'b0;
        expect_v("rf_x0_after", S_RS1, 32'h0);

        // RF reset beats a simultaneous write
        step();
        rf_we = 1'b1; rf_waddr = 5'd7; rf_wdata = 32'hA5A5_A5A5;
        step();
        rf_we = 1'b0; rf_rs1_addr = 5'd7;
        expect_v("rf_x7", S_RS1, 32'hA5A5_A5A5);
        step();
        reset = 1'b1; rf_we = 1'b1; rf_waddr = 5'd7; rf_wdata = 32'h1;
        expect_v("rf_x7_prerst", S_RS1, 32'hA5A5_A5A5);

        // After this edge all state is zero and the counter starts
        step();
        reset = 1'b0; rf_we = 1'b0; csr_addr = 12'hC00;
        expect_v("rf_x7_rst", S_RS1, 32'h0);
        expect_v("rf_x5_rst", S_RS2, 32'h0);
        expect_v("cyc_zero", S_CSR, 32'h0);
        for (int i = 0; i < 10; i++) step();
        csr_cmd = 2'd1; csr_wdata = 32'h5555;
        expect_v("cyc_10", S_CSR, 32'd10);
        step();
        csr_cmd = 2'd0; csr_addr = 12'hC80;
        expect_v("cych_0", S_CSR, 32'h0);
        step();
        csr_addr = 12'hC00;
        expect_v("cyc_wr_ign", S_CSR, 32'd12);

        // mscratch W/S/C: each command cycle shows the prior value
        csr_op("msc_w",  2'd1, 12'h340, 32'h0000_00F0, 32'h0);
        csr_op("msc_s",  2'd2, 12'h340, 32'h0000_000F, 32'h0000_00F0);
        csr_op("msc_c",  2'd3, 12'h340, 32'h0000_003C, 32'h0000_00FF);
        csr_op("msc_rd", 2'd0, 12'h340, 32'hFFFF_FFFF, 32'h0000_00C3);
        csr_op("mepc_w",  2'd1, 12'h341, 32'h0000_1003, 32'h0);
        csr_op("mepc_rd", 2'd0, 12'h341, 32'h0,         32'h0000_1000);
        csr_op("unimp_w",  2'd1, 12'h7C0, 32'h0000_1234, 32'h0);
        csr_op("unimp_rd", 2'd0, 12'h7C0, 32'h0,         32'h0);
        csr_op("mcause_s",  2'd2, 12'h342, 32'h8000_0003, 32'h0);
        csr_op("mcause_rd", 2'd0, 12'h342, 32'h0,         32'h8000_0003);
        csr_op("mstat_rd",  2'd0, 12'h300, 32'h0,         32'h0);

        // Counter low-to-high carry, starting from low word all ones
        step();
        force dut.u_csr.cycle_q = 64'h0000_0000_FFFF_FFFF;
        #1;
        release dut.u_csr.cycle_q;
        csr_addr = 12'hC00;
        expect_v("cyc_preset", S_CSR, 32'hFFFF_FFFF);
        step();
        expect_v("cyc_wrap_lo", S_CSR, 32'h0);
        step();
        csr_addr = 12'hC80;
        expect_v("cyc_wrap_hi", S_CSR, 32'h1);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && q.size() > 0; i++) step();
        if (q.size() > 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/exec_core_units.md
Name: exec_core_units

Overview:
- Bundles the three execute/writeback building blocks of the five-stage RV32 fixed-point pipeline:
  - a combinational ALU;
  - a 32x32 integer register file (two read ports, one write port);
  - a small machine-mode CSR file.
- The datapath drives the RF read ports from decode, the ALU from execute, and the CSR file and RF write port from the memory/writeback stages.
- All three sub-functions are independent apart from the shared clock and reset.

Parameters:
- XLEN, 32, data width of ALU, register file and CSRs.
- NREGS, 32, number of integer registers; index 0 reads as zero.

Ports:
- clk  input  1  clock; everything samples on the rising edge.
- reset  input  1  synchronous, active-high reset.
- alu_op1  input  32  ALU operand 1.
- alu_op2  input  32  ALU operand 2.
- alu_fun  input  4  ALU function select (encoding below).
- alu_out  output  32  ALU result (combinational).
- rf_rs1_addr  input  5  read port 1 address.
- rf_rs2_addr  input  5  read port 2 address.
- rf_rs1_data  output  32  read port 1 data (combinational).
- rf_rs2_data  output  32  read port 2 data (combinational).
- rf_waddr  input  5  write address.
- rf_wdata  input  32  write data.
- rf_we  input  1  write enable.
- csr_cmd  input  2  0=N (none), 1=W (write), 2=S (set bits), 3=C (clear bits).
- csr_addr  input  12  CSR address (instruction bits 31:20).
- csr_wdata  input  32  CSR operand.
- csr_rdata  output  32  current (pre-update) CSR value (combinational).

Behaviour:
- ALU is purely combinational; result is valid in the same cycle. Encoding of alu_fun:
  - 0 ADD: op1+op2, mod 2^32.
  - 1 SUB: op1-op2, mod 2^32.
  - 2 SLL: op1 << op2[4:0].
  - 3 SRL: logical right shift by op2[4:0].
  - 4 SRA: arithmetic right shift by op2[4:0].
  - 5 AND, 6 OR, 7 XOR.
  - 8 SLT: signed compare, result 1/0.
  - 9 SLTU: unsigned compare, result 1/0.
  - 10 COPY1: op1.
  - 11-15: result 0.
  - Only op2[4:0] is used for shifts; op2[31:5] is ignored.
- Register file:
  - Reads are asynchronous.
  - Write occurs at the rising edge when rf_we=1 and rf_waddr!=0.
  - Writes to x0 are discarded; reads of address 0 always return 0.
  - No internal write-to-read bypass: a read of the register being written in the same cycle returns the old value. The datapath provides bypassing externally.
  - Both read ports may address the same register.
  - reset=1 clears all registers to 0 at the next edge and has priority over a simultaneous write.
- CSR file, implemented registers (reset value 0 for all):
  - 0x300 mstatus.
  - 0x305 mtvec.
  - 0x340 mscratch.
  - 0x341 mepc; bits 1:0 are forced to 0 on write.
  - 0x342 mcause.
  - 0xC00 cycle, low 32 bits of a 64-bit cycle counter.
  - 0xC80 cycleh, high 32 bits of the same counter.
- CSR reads:
  - csr_rdata always reflects the addressed CSR's value before any update in the current cycle.
  - It is driven regardless of csr_cmd.
  - Unimplemented addresses read 0.
- CSR updates, applied at the rising edge:
  - W: new = wdata.
  - S: new = old | wdata.
  - C: new = old & ~wdata.
  - N: no change.
  - Writes to unimplemented addresses and to cycle/cycleh are ignored.
- Cycle counter:
  - 64 bits; increments by 1 every clock when reset=0.
  - Wraps from all-ones to 0.
  - Reset forces it to 0; the first clock after reset deasserts yields 1.
  - The low-to-high carry is exact, e.g. 0x0000_0000_FFFF_FFFF -> 0x0000_0001_0000_0000.
- Reset mid-operation: any CSR or RF write presented in a cycle with reset=1 is lost. All state is 0 after that edge.
- No X propagation: all outputs are defined for all input codes.

Test Plan:
- ALU sweep:
  - op1=0xFFFF_FFF0, op2=0x0000_0014: ADD->0x0000_0004, SUB->0xFFFF_FFDC.
  - SRA with op2=0x24 (shift 4) -> 0xFFFF_FFFF; SRL -> 0x0FFF_FFFF.
  - SLT->1, SLTU->0, fun=12 -> 0.
- RF basic:
  - Write x5=0xDEAD_BEEF. In the same cycle, rs1=5 reads the old value 0; the next cycle it reads 0xDEAD_BEEF on both ports.
  - Write x0=0x1234 with rf_we=1 -> rs1=0 still reads 0.
- RF reset: write x7=0xA5A5_A5A5, then a cycle with reset=1 plus a simultaneous write x7=0x1 -> x7 reads 0 after the edge.
- CSR R/W/S/C on mscratch 0x340:
  - W 0x0000_00F0 -> read 0xF0.
  - S 0x0F -> 0xFF.
  - C 0x3C -> 0xC3.
  - Throughout, csr_rdata during each command cycle shows the prior value.
- CSR special cases:
  - W 0x0000_1003 to mepc -> reads 0x0000_1000.
  - W to 0x7C0 (unimplemented) -> reads 0.
  - W to 0xC00 is ignored; cycle keeps counting.
- Counter: release reset, wait 10 clocks -> cycle reads 10 and cycleh 0. With the low word at 0xFFFF_FFFF, one clock later cycle=0 and cycleh=1.
